lsu_align: RTL

Load/store alignment unit between the single-cycle core's memory stage and the word-addressed data memory. The data memory only services word-aligned accesses. This block accepts byte, halfword and word requests at any byte address. It turns each request into aligned full-word reads (LW) and writes (SW) on the memory side. Sub-word and misaligned stores use read-modify-write. Accesses that cross a word boundary are split into two word accesses.

---
 rtl/lsu_align.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_align.sv
// Load/store alignment unit: maps byte/half/word requests at any byte address onto
// aligned word reads and writes, with read-modify-write for partial stores and word splitting.
module lsu_align #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_rsel,
  input  logic [1:0]  req_wsel,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  output logic [2:0]  mem_rsel,
  output logic [1:0]  mem_wsel,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP1, WR0, WR1, RESP} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   addr_q, wdata_q, buf0_q, buf1_q;
  logic            we_q;
  logic [2:0]      rsel_q;
  logic [1:0]      wsel_q;
  logic            req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d, mem_rw_q, mem_rw_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d, mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic [DW-1:0]   cur_addr, cur_wdata, buf0_d, buf1_d, w0, w1, dword, load_val;
  logic            cur_we, legal, span, aligned_sw;
  logic [2:0]      cur_rsel, size;
  logic [1:0]      cur_wsel, off;
  logic [3:0]      mask4;
  logic [7:0]      mask8;
  logic [2*DW-1:0] sdata, merged;

  // In IDLE the request inputs are decoded directly; afterwards the latched copy.
  always_comb begin
    cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    cur_we    = (state_q == IDLE) ? req_we    : we_q;
    cur_rsel  = (state_q == IDLE) ? req_rsel  : rsel_q;
    cur_wsel  = (state_q == IDLE) ? req_wsel  : wsel_q;
    off       = cur_addr[1:0];
    w0        = {cur_addr[31:2], 2'b00};
    w1        = w0 + 32'd4;
    legal     = 1'b1;
    size      = 3'd4;
    mask4     = 4'hF;
    if (cur_we) begin
      case (cur_wsel)
        2'b00:   begin size = 3'd1; mask4 = 4'h1; end
        2'b01:   begin size = 3'd2; mask4 = 4'h3; end
        2'b10:   begin size = 3'd4; mask4 = 4'hF; end
        default: legal = 1'b0;
      endcase
    end else begin
      case (cur_rsel)
        3'b000, 3'b100: size = 3'd1;
        3'b010, 3'b101: size = 3'd2;
        3'b011:         size = 3'd4;
        default:        legal = 1'b0;
      endcase
    end
    span       = (3'({1'b0, off}) + size) > 3'd4;
    aligned_sw = cur_we && (cur_wsel == 2'b10) && (off == 2'b00);

    // Buffers capture memory data in the cycle it is valid; use it the same cycle.
    buf0_d = (state_q == RD1)  ? mem_rdata : buf0_q;
    buf1_d = (state_q == CAP1) ? mem_rdata : buf1_q;
    dword  = 32'({buf1_d, buf0_d} >> {off, 3'b000});
    case (cur_rsel)
      3'b000:  load_val = {{24{dword[7]}}, dword[7:0]};
      3'b100:  load_val = {24'd0, dword[7:0]};
      3'b010:  load_val = {{16{dword[15]}}, dword[15:0]};
      3'b101:  load_val = {16'd0, dword[15:0]};
      3'b011:  load_val = dword;
      default: load_val = '0;
    endcase
    mask8 = 8'(mask4) << off;
    sdata = 64'(cur_wdata) << {off, 3'b000};
    for (int i = 0; i < 8; i++)
      merged[8*i +: 8] = mask8[i] ? sdata[8*i +: 8] : ((i < 4) ? buf0_d[8*(i%4) +: 8]
                                                               : buf1_d[8*(i%4) +: 8]);
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rw_d     = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        if (!legal || (span && !SPLIT_EN)) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end else if (aligned_sw) begin
          state_d     = WR0;
          mem_addr_d  = w0;
          mem_rw_d    = 1'b1;
          mem_wdata_d = cur_wdata;
        end else begin
          state_d    = RD0;
          mem_addr_d = w0;
        end
      end
      RD0: begin
        state_d = RD1;
        if (span) mem_addr_d = w1;
      end
      RD1, CAP1: begin
        if (state_q == RD1 && span) begin
          state_d = CAP1;
        end else if (cur_we) begin
          state_d     = WR0;
          mem_addr_d  = w0;
          mem_rw_d    = 1'b1;
          mem_wdata_d = merged[31:0];
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_val;
        end
      end
      WR0: begin
        if (span) begin
          state_d     = WR1;
          mem_addr_d  = w1;
          mem_rw_d    = 1'b1;
          mem_wdata_d = merged[63:32];
        end else begin
          state_d = RESP;
        end
      end
      WR1:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rsel_q       <= '0;
      wsel_q       <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
        rsel_q  <= req_rsel;
        wsel_q  <= req_wsel;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rw     = mem_rw_q;
  assign mem_rsel   = 3'b011;
  assign mem_wsel   = 2'b10;

endmodule
